// File: rtl/unpadding_if.sv
// unpadding_if: beat-level bus of the unpadding stage.
//   input_vld      : padded input beat valid (no backpressure)
//   input_din      : padded pixel, CHANNEL samples of N bits, channel 0 in LSBs
//   unpad_dout     : interior pixel (registered)
//   unpad_dout_vld : unpad_dout valid, one cycle per interior pixel
//   unpad_dout_end : 1 when idle / between frames, 0 while a frame is in progress
//   frame_done     : one-cycle pulse after the last padded beat of a frame
//   border_err     : sticky flag, non-zero border content seen since reset
// Modport slave is the unpadding block's view; master is the producer/consumer side.
interface unpadding_if #(
  parameter int N       = 8,
  parameter int CHANNEL = 3
);
  logic                 input_vld;
  logic [CHANNEL*N-1:0] input_din;
  logic [CHANNEL*N-1:0] unpad_dout;
  logic                 unpad_dout_vld;
  logic                 unpad_dout_end;
  logic                 frame_done;
  logic                 border_err;

  modport slave (
    input  input_vld,
    input  input_din,
    output unpad_dout,
    output unpad_dout_vld,
    output unpad_dout_end,
    output frame_done,
    output border_err
  );

  modport master (
    output input_vld,
    output input_din,
    input  unpad_dout,
    input  unpad_dout_vld,
    input  unpad_dout_end,
    input  frame_done,
    input  border_err
  );
endinterface

// File: rtl/unpadding.sv
// unpadding: strips a PADDING-wide border from a raster-order stream of
// (SIZE+2*PADDING)^2 multi-channel pixels and emits the SIZE*SIZE interior
// pixels in raster order with one cycle of registered latency. Non-zero
// border beats set a sticky debug flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over ce / input_vld)
//   ce   : block enable; low discards any partial frame and clears counters
//   bus  : unpadding_if.slave carrying the input beat and all outputs
// The interface instance must be parameterised with the same N / CHANNEL.
module unpadding #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int PADDING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  unpadding_if.slave  bus
);

  localparam int W  = SIZE + 2 * PADDING;
  // One spare bit so that W itself (and PADDING+SIZE) is representable.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  state_t               state;
  logic [CW-1:0]        row;
  logic [CW-1:0]        col;
  logic [CHANNEL*N-1:0] dout_q;
  logic                 dout_vld_q;
  logic                 done_q;
  logic                 err_q;

  logic interior;
  logic last_beat;

  generate
    if (PADDING == 0) begin : g_no_pad
      assign interior = 1'b1;
    end else begin : g_pad
      localparam logic [CW-1:0] LO = CW'(PADDING);
      localparam logic [CW-1:0] HI = CW'(PADDING + SIZE);
      assign interior = (row >= LO) && (row < HI) && (col >= LO) && (col < HI);
    end
  endgenerate

  assign last_beat = (row == LAST_IDX) && (col == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (!ce) begin
      // Soft clear: data word and sticky error survive, frame position does not.
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.input_vld) begin
      dout_vld_q <= interior;
      if (interior) begin
        dout_q <= bus.input_din;
      end else if (bus.input_din != '0) begin
        err_q <= 1'b1;
      end
      if (last_beat) begin
        row    <= '0;
        col    <= '0;
        done_q <= 1'b1;
        state  <= ST_IDLE;
      end else begin
        done_q <= 1'b0;
        state  <= ST_FRAME;
        if (col == LAST_IDX) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end else begin
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end
  end

  assign bus.unpad_dout     = dout_q;
  assign bus.unpad_dout_vld = dout_vld_q;
  assign bus.unpad_dout_end = (state == ST_IDLE);
  assign bus.frame_done     = done_q;
  assign bus.border_err     = err_q;

endmodule

// File: tb/tb_unpadding.sv
module tb_unpadding;

  localparam int N  = 8;
  localparam int CH = 3;
  localparam int DW = N * CH;

  logic clk = 1'b0;
  logic rst;
  logic ce1;
  logic ce0;

  int checks = 0;
  int fails  = 0;

  // Interior values of a 6x6 frame whose beat i carries value i.
  int exp_px [16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  unpadding_if #(.N(N), .CHANNEL(CH)) bus1 ();
  unpadding_if #(.N(N), .CHANNEL(CH)) bus0 ();

  unpadding #(.N(N), .CHANNEL(CH), .SIZE(4), .PADDING(1)) dut_p1 (
    .clk (clk),
    .rst (rst),
    .ce  (ce1),
    .bus (bus1)
  );

  unpadding #(.N(N), .CHANNEL(CH), .SIZE(4), .PADDING(0)) dut_p0 (
    .clk (clk),
    .rst (rst),
    .ce  (ce0),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  function automatic bit is_int(input int i);
    int r;
    int c;
    r = i / 6;
    c = i % 6;
    return (r >= 1) && (r <= 4) && (c >= 1) && (c <= 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus1.input_vld = 1'b0;
    bus1.input_din = '0;
    bus0.input_vld = 1'b0;
    bus0.input_din = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce1 = 1'b1;
    ce0 = 1'b1;
    bus1.input_vld = 1'b1;
    bus1.input_din = 24'h123456;
    bus0.input_vld = 1'b0;
    bus0.input_din = '0;
    tick();
    tick();
    checks++; if (bus1.unpad_dout !== '0) begin fails++; $display("FAIL reset_dout got %h want 000000", bus1.unpad_dout); end
    checks++; if (bus1.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", bus1.unpad_dout_vld); end
    checks++; if (bus1.unpad_dout_end !== 1'b1) begin fails++; $display("FAIL reset_end got %b want 1", bus1.unpad_dout_end); end
    checks++; if (bus1.frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus1.frame_done); end
    checks++; if (bus1.border_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus1.border_err); end
    rst = 1'b0;
    bus1.input_vld = 1'b0;
  endtask

  task automatic test_contiguous();
    int k;
    do_reset();
    k = 0;
    for (int i = 0; i < 36; i++) begin
      bus1.input_vld = 1'b1;
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
      checks++; if (bus1.unpad_dout_vld !== is_int(i)) begin fails++; $display("FAIL contig_vld beat %0d got %b want %b", i, bus1.unpad_dout_vld, is_int(i)); end
      if (is_int(i)) begin
        checks++; if (bus1.unpad_dout !== DW'(exp_px[k])) begin fails++; $display("FAIL contig_dout beat %0d got %0d want %0d", i, bus1.unpad_dout, exp_px[k]); end
        k++;
      end
      checks++; if (bus1.frame_done !== (i == 35)) begin fails++; $display("FAIL contig_done beat %0d got %b want %b", i, bus1.frame_done, (i == 35)); end
      checks++; if (bus1.unpad_dout_end !== (i == 35)) begin fails++; $display("FAIL contig_end beat %0d got %b want %b", i, bus1.unpad_dout_end, (i == 35)); end
    end
    bus1.input_vld = 1'b0;
    tick();
    checks++; if (k !== 16) begin fails++; $display("FAIL contig_count got %0d want 16", k); end
    checks++; if (bus1.frame_done !== 1'b0) begin fails++; $display("FAIL contig_done_after got %b want 0", bus1.frame_done); end
    checks++; if (bus1.unpad_dout_end !== 1'b1) begin fails++; $display("FAIL contig_end_after got %b want 1", bus1.unpad_dout_end); end
    checks++; if (bus1.border_err !== 1'b0) begin fails++; $display("FAIL contig_err got %b want 0", bus1.border_err); end
  endtask

  task automatic test_gaps();
    int k;
    do_reset();
    k = 0;
    for (int i = 0; i < 36; i++) begin
      bus1.input_vld = 1'b1;
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
      checks++; if (bus1.unpad_dout_vld !== is_int(i)) begin fails++; $display("FAIL gap_vld beat %0d got %b want %b", i, bus1.unpad_dout_vld, is_int(i)); end
      if (is_int(i)) begin
        checks++; if (bus1.unpad_dout !== DW'(exp_px[k])) begin fails++; $display("FAIL gap_dout beat %0d got %0d want %0d", i, bus1.unpad_dout, exp_px[k]); end
        k++;
      end
      checks++; if (bus1.frame_done !== (i == 35)) begin fails++; $display("FAIL gap_done beat %0d got %b want %b", i, bus1.frame_done, (i == 35)); end
      // Idle cycle: garbage on din must be ignored and counters must hold.
      bus1.input_vld = 1'b0;
      bus1.input_din = 24'hFFFFFF;
      tick();
      checks++; if (bus1.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL gap_idle_vld beat %0d got %b want 0", i, bus1.unpad_dout_vld); end
      checks++; if (bus1.frame_done !== 1'b0) begin fails++; $display("FAIL gap_idle_done beat %0d got %b want 0", i, bus1.frame_done); end
      checks++; if (bus1.unpad_dout_end !== (i == 35)) begin fails++; $display("FAIL gap_idle_end beat %0d got %b want %b", i, bus1.unpad_dout_end, (i == 35)); end
    end
    checks++; if (k !== 16) begin fails++; $display("FAIL gap_count got %0d want 16", k); end
    checks++; if (bus1.border_err !== 1'b0) begin fails++; $display("FAIL gap_err got %b want 0", bus1.border_err); end
  endtask

  task automatic test_back_to_back();
    int k;
    int ndone;
    int last_done;
    do_reset();
    k = 0;
    ndone = 0;
    last_done = -1;
    for (int i = 0; i < 72; i++) begin
      bus1.input_vld = 1'b1;
      bus1.input_din = is_int(i % 36) ? DW'(i % 36) : '0;
      tick();
      checks++; if (bus1.unpad_dout_vld !== is_int(i % 36)) begin fails++; $display("FAIL b2b_vld beat %0d got %b want %b", i, bus1.unpad_dout_vld, is_int(i % 36)); end
      if (bus1.unpad_dout_vld === 1'b1) begin
        checks++; if (bus1.unpad_dout !== DW'(exp_px[k % 16])) begin fails++; $display("FAIL b2b_dout beat %0d got %0d want %0d", i, bus1.unpad_dout, exp_px[k % 16]); end
        k++;
      end
      if (bus1.frame_done === 1'b1) begin
        if (last_done >= 0) begin
          checks++; if (i - last_done !== 36) begin fails++; $display("FAIL b2b_spacing got %0d want 36", i - last_done); end
        end
        last_done = i;
        ndone++;
      end
      checks++; if (bus1.unpad_dout_end !== (i % 36 == 35)) begin fails++; $display("FAIL b2b_end beat %0d got %b want %b", i, bus1.unpad_dout_end, (i % 36 == 35)); end
    end
    bus1.input_vld = 1'b0;
    tick();
    checks++; if (k !== 32) begin fails++; $display("FAIL b2b_count got %0d want 32", k); end
    checks++; if (ndone !== 2) begin fails++; $display("FAIL b2b_ndone got %0d want 2", ndone); end
  endtask

  task automatic test_border_err();
    do_reset();
    bus1.input_vld = 1'b1;
    bus1.input_din = 24'h000001;
    tick();
    checks++; if (bus1.border_err !== 1'b1) begin fails++; $display("FAIL berr_set got %b want 1", bus1.border_err); end
    checks++; if (bus1.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL berr_vld got %b want 0", bus1.unpad_dout_vld); end
    for (int i = 1; i < 36; i++) begin
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
    end
    checks++; if (bus1.border_err !== 1'b1) begin fails++; $display("FAIL berr_frame_end got %b want 1", bus1.border_err); end
    ce1 = 1'b0;
    tick();
    tick();
    checks++; if (bus1.border_err !== 1'b1) begin fails++; $display("FAIL berr_ce_low got %b want 1", bus1.border_err); end
    ce1 = 1'b1;
    for (int i = 0; i < 36; i++) begin
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
    end
    checks++; if (bus1.border_err !== 1'b1) begin fails++; $display("FAIL berr_next_frame got %b want 1", bus1.border_err); end
    bus1.input_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus1.border_err !== 1'b0) begin fails++; $display("FAIL berr_rst got %b want 0", bus1.border_err); end
  endtask

  task automatic test_ce_drop();
    int k;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      bus1.input_vld = 1'b1;
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
    end
    checks++; if (bus1.unpad_dout !== DW'(20)) begin fails++; $display("FAIL ce_pre_dout got %0d want 20", bus1.unpad_dout); end
    ce1 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus1.input_din = 24'h0A0B0C;
      tick();
      checks++; if (bus1.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL ce_low_vld cyc %0d got %b want 0", j, bus1.unpad_dout_vld); end
      checks++; if (bus1.unpad_dout_end !== 1'b1) begin fails++; $display("FAIL ce_low_end cyc %0d got %b want 1", j, bus1.unpad_dout_end); end
      checks++; if (bus1.unpad_dout !== DW'(20)) begin fails++; $display("FAIL ce_low_dout cyc %0d got %0d want 20", j, bus1.unpad_dout); end
    end
    ce1 = 1'b1;
    k = 0;
    for (int i = 0; i < 36; i++) begin
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
      checks++; if (bus1.unpad_dout_vld !== is_int(i)) begin fails++; $display("FAIL ce_vld beat %0d got %b want %b", i, bus1.unpad_dout_vld, is_int(i)); end
      if (bus1.unpad_dout_vld === 1'b1) begin
        checks++; if (bus1.unpad_dout !== DW'(exp_px[k % 16])) begin fails++; $display("FAIL ce_dout beat %0d got %0d want %0d", i, bus1.unpad_dout, exp_px[k % 16]); end
        k++;
      end
      checks++; if (bus1.frame_done !== (i == 35)) begin fails++; $display("FAIL ce_done beat %0d got %b want %b", i, bus1.frame_done, (i == 35)); end
    end
    bus1.input_vld = 1'b0;
    tick();
    checks++; if (k !== 16) begin fails++; $display("FAIL ce_count got %0d want 16", k); end
  endtask

  task automatic test_rst_mid();
    int k;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus1.input_vld = 1'b1;
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
    end
    rst = 1'b1;
    bus1.input_din = DW'(16);
    tick();
    rst = 1'b0;
    checks++; if (bus1.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL rstmid_vld got %b want 0", bus1.unpad_dout_vld); end
    checks++; if (bus1.unpad_dout !== '0) begin fails++; $display("FAIL rstmid_dout got %h want 000000", bus1.unpad_dout); end
    checks++; if (bus1.unpad_dout_end !== 1'b1) begin fails++; $display("FAIL rstmid_end got %b want 1", bus1.unpad_dout_end); end
    checks++; if (bus1.frame_done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", bus1.frame_done); end
    k = 0;
    for (int i = 0; i < 36; i++) begin
      bus1.input_din = is_int(i) ? DW'(i) : '0;
      tick();
      checks++; if (bus1.unpad_dout_vld !== is_int(i)) begin fails++; $display("FAIL rstmid_fr_vld beat %0d got %b want %b", i, bus1.unpad_dout_vld, is_int(i)); end
      if (bus1.unpad_dout_vld === 1'b1) begin
        checks++; if (bus1.unpad_dout !== DW'(exp_px[k % 16])) begin fails++; $display("FAIL rstmid_fr_dout beat %0d got %0d want %0d", i, bus1.unpad_dout, exp_px[k % 16]); end
        k++;
      end
    end
    bus1.input_vld = 1'b0;
    tick();
    checks++; if (k !== 16) begin fails++; $display("FAIL rstmid_count got %0d want 16", k); end
  endtask

  task automatic test_pad0();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = {8'(i + 1), 8'(i * 3), 8'(8'hA0 + i)};
      bus0.input_vld = 1'b1;
      bus0.input_din = d;
      tick();
      checks++; if (bus0.unpad_dout_vld !== 1'b1) begin fails++; $display("FAIL pad0_vld beat %0d got %b want 1", i, bus0.unpad_dout_vld); end
      checks++; if (bus0.unpad_dout !== d) begin fails++; $display("FAIL pad0_dout beat %0d got %h want %h", i, bus0.unpad_dout, d); end
      checks++; if (bus0.frame_done !== (i == 15)) begin fails++; $display("FAIL pad0_done beat %0d got %b want %b", i, bus0.frame_done, (i == 15)); end
      checks++; if (bus0.unpad_dout_end !== (i == 15)) begin fails++; $display("FAIL pad0_end beat %0d got %b want %b", i, bus0.unpad_dout_end, (i == 15)); end
    end
    bus0.input_vld = 1'b0;
    tick();
    checks++; if (bus0.unpad_dout_vld !== 1'b0) begin fails++; $display("FAIL pad0_idle_vld got %b want 0", bus0.unpad_dout_vld); end
    checks++; if (bus0.border_err !== 1'b0) begin fails++; $display("FAIL pad0_err got %b want 0", bus0.border_err); end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_back_to_back();
    test_border_err();
    test_ce_drop();
    test_rst_mid();
    test_pad0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/unpadding.md
Name: unpadding

Overview:
- Inverse of the zero-padding stage in the NN datapath.
- Consumes a raster-order stream of (SIZE+2*PADDING)^2 multi-channel pixels and strips the PADDING-wide border.
- Emits only the SIZE*SIZE interior pixels, in raster order, with one cycle of registered latency.
- Sits after padded feature-map producers and before dense or export stages. Also flags non-zero border content for debug.

Parameters:
- N, 8, bit width of one channel sample
- CHANNEL, 3, channels carried in parallel per beat
- SIZE, 32, interior (output) feature-map side length
- PADDING, 1, border width stripped on each side; 0 makes the block a pass-through with counters

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- ce  input  1  block enable; low acts as a soft clear (see Behaviour)
- input_vld  input  1  input beat valid; no backpressure, every valid beat is consumed
- input_din  input  CHANNEL*N  padded pixel, channel 0 in the LSBs
- unpad_dout  output  CHANNEL*N  interior pixel (registered)
- unpad_dout_vld  output  1  unpad_dout valid, one cycle per interior pixel
- unpad_dout_end  output  1  level: 1 when idle or between frames, 0 while a frame is in progress
- frame_done  output  1  one-cycle pulse after the last padded beat of a frame
- border_err  output  1  sticky: a non-zero border beat was seen since reset

Behaviour:
- Let W = SIZE+2*PADDING. Internal counters: row and col, each 0..W-1, both clog2(W) bits min (32-bit acceptable).

Reset (rst=1 at posedge):
- row=0, col=0.
- unpad_dout=0, unpad_dout_vld=0, unpad_dout_end=1, frame_done=0, border_err=0.
- rst has priority over ce and input_vld.

ce=0 (rst=0):
- row=0, col=0.
- unpad_dout_vld=0, frame_done=0, unpad_dout_end=1.
- unpad_dout and border_err hold.
- A partial frame is discarded. The next frame restarts at (0,0).

Accept (rst=0, ce=1, input_vld=1) at position (row,col):
- Interior beat, i.e. PADDING<=row<PADDING+SIZE and PADDING<=col<PADDING+SIZE: next cycle unpad_dout=input_din and unpad_dout_vld=1.
- Border beat: next cycle unpad_dout_vld=0 and unpad_dout holds. If input_din != 0, border_err<=1.
- unpad_dout_end<=0 on every accepted beat except the last of the frame.
- Advance: if col==W-1 then col=0 and row increments, else col increments.
- Last beat (row==W-1 and col==W-1): row=0, col=0; next cycle frame_done=1 and unpad_dout_end=1.

Idle (rst=0, ce=1, input_vld=0):
- Counters hold.
- unpad_dout_vld=0, frame_done=0, unpad_dout_end holds.

Latency and ordering:
- Latency input beat to output: exactly 1 cycle.
- Output order is raster over the interior. Gaps on the input propagate 1:1 to the output.
- Back-to-back frames are allowed. A beat on the cycle after the last beat is row 0, col 0 of the next frame: frame_done=1 and unpad_dout_end=1 that cycle, and unpad_dout_end falls to 0 the following cycle.

PADDING=0:
- Every beat is interior, so the output is the input delayed 1 cycle.
- frame_done still pulses every SIZE*SIZE beats.

Counts:
- Exactly SIZE*SIZE unpad_dout_vld pulses per completed frame.
- The last interior pixel always precedes frame_done (whenever PADDING>0).

Test Plan:
- SIZE=4, PADDING=1, rst then 36 contiguous beats, din=index 0..35 (border beats forced to 0) -> 16 vld pulses with values 7,8,9,10,13..16,19..22,25..28. First vld 1 cycle after beat 7. frame_done pulses 1 cycle after beat 35. border_err=0.
- Same frame with input_vld toggling 1010... -> identical output sequence. Each vld exactly 1 cycle after its input beat. Counters hold during gaps.
- Two frames back-to-back, no gap -> 32 vld pulses. frame_done pulses twice, 36 cycles apart. unpad_dout_end=1 for exactly one cycle between frames.
- Beat 0 (border) carries 0x000001 -> border_err=1 from the next cycle. It stays 1 through ce=0 and later frames, and clears only on rst.
- ce dropped after beat 20, then raised and a full 36-beat frame sent -> no output while ce=0. Next frame starts at (0,0) and yields exactly 16 pixels, values as in the first scenario.
- rst asserted mid-frame together with input_vld=1 -> no vld next cycle. All outputs take their reset values. The following frame decodes correctly.
- PADDING=0, SIZE=4, 16 beats -> 16 outputs equal to the inputs, each delayed 1 cycle. frame_done 1 cycle after beat 15.
